ps2_command_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xF4 enable.
- Runs in the CLOCK_50 domain beside the existing PS/2 receive path.
- Drives the open-drain PS2_CLK/PS2_DAT lines through active-high pull-low enables. The top level performs the tristating: line = oe ? 0 : Z.
- Reports completion, missing acknowledge, or timeout to the keyboard-control logic.

---
 rtl/ps2_command_tx.sv | 235 +++++++++++++++++++++++
 tb/tb_ps2_command_tx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_command_tx.sv
// ps2_command_tx: host-to-device PS/2 command transmitter.
//   It inhibits the bus and issues a request-to-send. It then shifts out
//   {start, data[7:0], odd parity, stop} on device clock falling edges and
//   checks the device acknowledge.
// Ports:
//   CLOCK_50, reset            - system clock, async active-high reset
//   command_byte, send_command - byte to send, one-cycle request (IDLE only)
//   ps2_clk_in, ps2_dat_in     - raw asynchronous pin levels
//   ps2_clk_oe, ps2_dat_oe     - registered pull-low enables for the pins
//   busy                       - high in every state except IDLE
//   command_was_sent, error_no_ack, error_communication_timed_out
//                              - one-cycle result pulses, one per command
module ps2_command_tx #(
  parameter int unsigned CLK_INHIBIT_CYCLES   = 5000,
  parameter int unsigned START_TIMEOUT_CYCLES = 750000,
  parameter int unsigned XFER_TIMEOUT_CYCLES  = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] command_byte,
  input  logic       send_command,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_no_ack,
  output logic       error_communication_timed_out
);

  localparam int unsigned MAX_A      = (CLK_INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
                                       CLK_INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_A > XFER_TIMEOUT_CYCLES) ? MAX_A : XFER_TIMEOUT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int unsigned FRAME_W    = 10;
  localparam int unsigned BIT_W      = 4;

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(CLK_INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] XFER_LAST    = CNT_W'(XFER_TIMEOUT_CYCLES - 1);
  // bit_cnt value when the falling edge that presents the stop bit arrives
  localparam logic [BIT_W-1:0] PRE_STOP_CNT = BIT_W'(9);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_DATA, S_ACK, S_WAIT_IDLE, S_ERR_TO
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 ack_bad_q, ack_bad_d;
  logic [2:0]           clk_sync_q, clk_sync_d;
  logic [1:0]           dat_sync_q, dat_sync_d;
  logic                 clk_oe_q, clk_oe_d;
  logic                 dat_oe_q, dat_oe_d;
  logic                 busy_q, busy_d;
  logic                 sent_q, sent_d;
  logic                 no_ack_q, no_ack_d;
  logic                 timeout_q, timeout_d;

  logic                 clk_fall;
  logic                 clk_cur;
  logic                 dat_cur;
  logic [CNT_W-1:0]     cnt_inc;

  // Pin synchronizers; the third clock stage gives the previous level for edge detection
  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], ps2_clk_in};
    dat_sync_d = {dat_sync_q[0], ps2_dat_in};
  end

  assign clk_cur  = clk_sync_q[1];
  assign dat_cur  = dat_sync_q[1];
  assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    ack_bad_d = ack_bad_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    sent_d    = 1'b0;
    no_ack_d  = 1'b0;
    timeout_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (send_command) begin
          shreg_d   = {1'b1, ~^command_byte, command_byte};
          cnt_d     = '0;
          bit_cnt_d = '0;
          ack_bad_d = 1'b0;
          clk_oe_d  = 1'b1;
          // a one-cycle inhibit already needs the start bit on its only cycle
          dat_oe_d  = (INHIBIT_LAST == '0);
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        cnt_d = cnt_inc;
        if (cnt_q == INHIBIT_LAST) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_RTS;
        end else if (cnt_inc == INHIBIT_LAST) begin
          // start bit goes low during the last inhibit cycle, before clock release
          dat_oe_d = 1'b1;
        end
      end

      S_RTS: begin
        cnt_d = cnt_inc;
        if (clk_fall) begin
          dat_oe_d  = ~shreg_q[0];
          shreg_d   = {1'b1, shreg_q[FRAME_W-1:1]};
          bit_cnt_d = BIT_W'(1);
          cnt_d     = '0;
          state_d   = S_DATA;
        end else if (cnt_q == START_LAST) begin
          clk_oe_d  = 1'b0;
          dat_oe_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_ERR_TO;
        end
      end

      S_DATA: begin
        cnt_d = cnt_inc;
        if (cnt_q == XFER_LAST) begin
          dat_oe_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_ERR_TO;
        end else if (clk_fall) begin
          // the stop bit is a 1, so edge 10 releases the data line
          dat_oe_d  = ~shreg_q[0];
          shreg_d   = {1'b1, shreg_q[FRAME_W-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == PRE_STOP_CNT) begin
            state_d = S_ACK;
          end
        end
      end

      S_ACK: begin
        cnt_d    = cnt_inc;
        dat_oe_d = 1'b0;
        if (cnt_q == XFER_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_ERR_TO;
        end else if (clk_fall) begin
          ack_bad_d = dat_cur;
          no_ack_d  = dat_cur;
          state_d   = S_WAIT_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        cnt_d = cnt_inc;
        if (cnt_q == XFER_LAST) begin
          // a missing ACK has already been reported; do not report a second result
          timeout_d = ~ack_bad_q;
          state_d   = ack_bad_q ? S_IDLE : S_ERR_TO;
        end else if (clk_cur && dat_cur) begin
          sent_d  = ~ack_bad_q;
          state_d = S_IDLE;
        end
      end

      S_ERR_TO: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = S_IDLE;
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      ack_bad_q  <= 1'b0;
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      sent_q     <= 1'b0;
      no_ack_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      ack_bad_q  <= ack_bad_d;
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      busy_q     <= busy_d;
      sent_q     <= sent_d;
      no_ack_q   <= no_ack_d;
      timeout_q  <= timeout_d;
    end
  end

  assign ps2_clk_oe                    = clk_oe_q;
  assign ps2_dat_oe                    = dat_oe_q;
  assign busy                          = busy_q;
  assign command_was_sent              = sent_q;
  assign error_no_ack                  = no_ack_q;
  assign error_communication_timed_out = timeout_q;

endmodule

// File: tb/tb_ps2_command_tx.sv
// tb_ps2_command_tx: bench for ps2_command_tx with a behavioural PS/2 device
// on a wired-AND bus, table-driven vectors, random commands and corner sequences.
module tb_ps2_command_tx;

  localparam int unsigned INH      = 50;
  localparam int unsigned START_TO = 1000;
  localparam int unsigned XFER_TO  = 2000;

  localparam int RES_SENT  = 0;
  localparam int RES_NOACK = 1;
  localparam int RES_TO    = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] command_byte = 8'h00;
  logic       send_command = 1'b0;
  logic       ps2_clk_oe, ps2_dat_oe, busy;
  logic       command_was_sent, error_no_ack, error_communication_timed_out;

  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic clk_line, dat_line;

  assign clk_line = dev_clk & ~ps2_clk_oe;
  assign dat_line = dev_dat & ~ps2_dat_oe;

  ps2_command_tx #(
    .CLK_INHIBIT_CYCLES  (INH),
    .START_TIMEOUT_CYCLES(START_TO),
    .XFER_TIMEOUT_CYCLES (XFER_TO)
  ) dut (
    .CLOCK_50                      (CLOCK_50),
    .reset                         (reset),
    .command_byte                  (command_byte),
    .send_command                  (send_command),
    .ps2_clk_in                    (clk_line),
    .ps2_dat_in                    (dat_line),
    .ps2_clk_oe                    (ps2_clk_oe),
    .ps2_dat_oe                    (ps2_dat_oe),
    .busy                          (busy),
    .command_was_sent              (command_was_sent),
    .error_no_ack                  (error_no_ack),
    .error_communication_timed_out (error_communication_timed_out)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;
  string tag = "init";

  // Running counts of output activity; checks use per-test deltas
  int n_sent = 0, n_noack = 0, n_to = 0, n_clk_oe = 0, n_sent_busy = 0;
  always @(negedge CLOCK_50) begin
    if (command_was_sent) n_sent++;
    if (error_no_ack) n_noack++;
    if (error_communication_timed_out) n_to++;
    if (ps2_clk_oe) n_clk_oe++;
    if (command_was_sent && busy) n_sent_busy++;
  end

  initial begin
    repeat (90000) @(posedge CLOCK_50);
    $display("FAIL watchdog: bench did not finish (tag=%s)", tag);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s/%s: got %0d expected %0d", tag, name, act, exp);
    end
  endtask

  // Reference: the 11-bit frame as the device sees it, index 0 = start bit
  function automatic logic [10:0] model_frame(input logic [7:0] c);
    logic [10:0] f;
    int ones;
    ones = 0;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = c[i];
      if (c[i]) ones++;
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  function automatic int model_result(input bit ack, input int nclk);
    if (nclk < 11) return RES_TO;
    return ack ? RES_NOACK : RES_SENT;
  endfunction

  // Device: waits for request-to-send, then clocks nclk times, sampling on rising edges
  task automatic device(input int half, input int nclk, input bit ack,
                        output logic [10:0] got, output bit rts_seen);
    got = '0;
    rts_seen = 1'b0;
    for (int w = 0; w < 400 && !rts_seen; w++) begin
      @(negedge CLOCK_50);
      if (clk_line && !dat_line) rts_seen = 1'b1;
    end
    if (!rts_seen) return;
    got[0] = dat_line;
    repeat (10) @(negedge CLOCK_50);
    for (int i = 1; i <= nclk; i++) begin
      if (i == 11) begin
        dev_dat = ack;
        repeat (2) @(negedge CLOCK_50);
      end
      dev_clk = 1'b0;
      repeat (half) @(negedge CLOCK_50);
      dev_clk = 1'b1;
      if (i <= 10) got[i] = dat_line;
      repeat (half) @(negedge CLOCK_50);
    end
    dev_dat = 1'b1;
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge CLOCK_50);
    command_byte = c;
    send_command = 1'b1;
    @(negedge CLOCK_50);
    send_command = 1'b0;
  endtask

  task automatic wait_not_busy(input int limit);
    int w;
    w = 0;
    while (busy && w < limit) begin
      @(negedge CLOCK_50);
      w++;
    end
    chk("busy_clears", int'(busy), 0);
  endtask

  typedef struct {
    logic [7:0] cmd;
    bit         ack;
    int         nclk;
    int         exp_res;
    bit         exp_par;
  } vec_t;

  task automatic run_txn(input vec_t v, input int half);
    logic [10:0] got, frame;
    bit rts;
    int s_sent, s_noack, s_to, s_oe, s_sb, nb;
    s_sent = n_sent; s_noack = n_noack; s_to = n_to; s_oe = n_clk_oe; s_sb = n_sent_busy;
    send(v.cmd);
    device(half, v.nclk, v.ack, got, rts);
    chk("rts_seen", int'(rts), 1);
    wait_not_busy(6000);
    repeat (5) @(negedge CLOCK_50);
    frame = model_frame(v.cmd);
    nb = (v.nclk < 10) ? v.nclk : 10;
    if (rts) begin
      chk("start_bit", int'(got[0]), 0);
      for (int i = 1; i <= nb; i++) chk($sformatf("bit%0d", i), int'(got[i]), int'(frame[i]));
      if (v.nclk >= 10) chk("parity", int'(got[9]), int'(v.exp_par));
    end
    chk("sent_pulses",  n_sent - s_sent,   (v.exp_res == RES_SENT)  ? 1 : 0);
    chk("noack_pulses", n_noack - s_noack, (v.exp_res == RES_NOACK) ? 1 : 0);
    chk("to_pulses",    n_to - s_to,       (v.exp_res == RES_TO)    ? 1 : 0);
    chk("inhibit_len",  n_clk_oe - s_oe,   int'(INH));
    chk("sent_while_busy", n_sent_busy - s_sb, 0);
    chk("clk_released", int'(ps2_clk_oe), 0);
    chk("dat_released", int'(ps2_dat_oe), 0);
  endtask

  vec_t tbl[6];

  initial begin
    int n, s_sent, s_noack, s_to, s_oe;
    logic [10:0] got;
    bit rts;
    vec_t v;

    tbl[0] = '{cmd: 8'hED, ack: 1'b0, nclk: 11, exp_res: RES_SENT,  exp_par: 1'b1};
    tbl[1] = '{cmd: 8'hF4, ack: 1'b0, nclk: 11, exp_res: RES_SENT,  exp_par: 1'b0};
    tbl[2] = '{cmd: 8'h00, ack: 1'b0, nclk: 11, exp_res: RES_SENT,  exp_par: 1'b1};
    tbl[3] = '{cmd: 8'hA5, ack: 1'b1, nclk: 11, exp_res: RES_NOACK, exp_par: 1'b1};
    tbl[4] = '{cmd: 8'h3C, ack: 1'b0, nclk: 4,  exp_res: RES_TO,    exp_par: 1'b1};
    tbl[5] = '{cmd: 8'h81, ack: 1'b0, nclk: 0,  exp_res: RES_TO,    exp_par: 1'b1};

    // reset state
    tag = "reset";
    repeat (3) @(negedge CLOCK_50);
    chk("clk_oe", int'(ps2_clk_oe), 0);
    chk("dat_oe", int'(ps2_dat_oe), 0);
    chk("busy", int'(busy), 0);
    chk("sent", int'(command_was_sent), 0);
    chk("noack", int'(error_no_ack), 0);
    chk("timeout", int'(error_communication_timed_out), 0);
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);

    // device clock activity while idle must not start anything
    tag = "idle_spurious";
    s_oe = n_clk_oe; s_to = n_to;
    for (int i = 0; i < 3; i++) begin
      dev_clk = 1'b0; repeat (20) @(negedge CLOCK_50);
      dev_clk = 1'b1; repeat (20) @(negedge CLOCK_50);
    end
    chk("busy", int'(busy), 0);
    chk("clk_oe_cycles", n_clk_oe - s_oe, 0);
    chk("dat_oe", int'(ps2_dat_oe), 0);
    chk("to_pulses", n_to - s_to, 0);

    // table vectors
    for (int i = 0; i < 6; i++) begin
      tag = $sformatf("table%0d", i);
      run_txn(tbl[i], 30);
    end

    // exact inhibit length and start-timeout latency
    tag = "start_timeout";
    send(8'h12);
    n = 0;
    while (!ps2_clk_oe && n < 10) begin @(negedge CLOCK_50); n++; end
    n = 0;
    while (ps2_clk_oe && n < 200) begin n++; @(negedge CLOCK_50); end
    chk("inhibit_cycles", n, int'(INH));
    chk("rts_dat_oe", int'(ps2_dat_oe), 1);
    n = 0;
    while (!error_communication_timed_out && n < 2000) begin @(negedge CLOCK_50); n++; end
    chk("rts_to_timeout_cycles", n, int'(START_TO));
    chk("clk_oe_at_err", int'(ps2_clk_oe), 0);
    chk("dat_oe_at_err", int'(ps2_dat_oe), 0);
    @(negedge CLOCK_50);
    chk("busy_after_err", int'(busy), 0);
    chk("pulse_width", int'(error_communication_timed_out), 0);

    // reset in the middle of the frame
    tag = "reset_mid";
    s_sent = n_sent; s_noack = n_noack; s_to = n_to;
    send(8'h00);
    device(30, 4, 1'b0, got, rts);
    chk("rts_seen", int'(rts), 1);
    chk("dat_oe_before", int'(ps2_dat_oe), 1);
    reset = 1'b1;
    #1;
    chk("clk_oe_in_reset", int'(ps2_clk_oe), 0);
    chk("dat_oe_in_reset", int'(ps2_dat_oe), 0);
    repeat (5) @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (2500) @(negedge CLOCK_50);
    chk("busy", int'(busy), 0);
    chk("pulses", (n_sent - s_sent) + (n_noack - s_noack) + (n_to - s_to), 0);

    // second request during an active transfer is dropped
    tag = "busy_drop";
    s_sent = n_sent; s_noack = n_noack; s_to = n_to; s_oe = n_clk_oe;
    send(8'hED);
    fork
      device(30, 11, 1'b0, got, rts);
      begin
        repeat (300) @(negedge CLOCK_50);
        chk("busy_at_second_req", int'(busy), 1);
        command_byte = 8'h55;
        send_command = 1'b1;
        @(negedge CLOCK_50);
        send_command = 1'b0;
      end
    join
    wait_not_busy(6000);
    repeat (500) @(negedge CLOCK_50);
    chk("frame", int'(got), int'(model_frame(8'hED)));
    chk("sent_pulses", n_sent - s_sent, 1);
    chk("other_pulses", (n_noack - s_noack) + (n_to - s_to), 0);
    chk("one_inhibit", n_clk_oe - s_oe, int'(INH));
    chk("busy_end", int'(busy), 0);

    // random commands against the reference model
    for (int i = 0; i < 8; i++) begin
      tag = $sformatf("rand%0d", i);
      v.cmd     = 8'($urandom_range(0, 255));
      v.ack     = 1'($urandom_range(0, 1));
      v.nclk    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 11;
      v.exp_res = model_result(v.ack, v.nclk);
      v.exp_par = model_frame(v.cmd)[9];
      run_txn(v, int'($urandom_range(20, 40)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
